// File: rtl/sync_sig_filter_lane.sv
// One lane of the destination-domain signal filter: deglitch counter, filtered level,
// registered edge pulses and a saturating rising-edge event counter.
module sync_sig_filter_lane #(
  parameter logic RST_VAL    = 1'b0,
  parameter int   FILTER_CYC = 4,
  parameter int   CNT_W      = 3,
  parameter int   EVT_W      = 16
) (
  input  logic             dst_clk,
  input  logic             dst_rst,
  input  logic             in,
  input  logic             evt_clr,
  output logic             out,
  output logic             rise,
  output logic             fall,
  output logic [EVT_W-1:0] evt_cnt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYC - 1);

  if (FILTER_CYC < 0 || (FILTER_CYC > 0 && (2 ** CNT_W) <= FILTER_CYC)) begin : g_bad_cnt_w
    $error("sync_sig_filter_lane: CNT_W=%0d cannot count to FILTER_CYC=%0d", CNT_W, FILTER_CYC);
  end

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             out_r;
  logic             out_nxt_s;
  logic             rise_r;
  logic             fall_r;
  logic [EVT_W-1:0] evt_r;
  logic [EVT_W-1:0] evt_nxt_s;

  // Next filtered level and hold counter; a return to in==out restarts the count
  always_comb begin
    out_nxt_s = out_r;
    cnt_nxt_s = cnt_r;
    if (FILTER_CYC == 0) begin
      out_nxt_s = in;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (in == out_r) begin
      cnt_nxt_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      out_nxt_s = in;
      cnt_nxt_s = {CNT_W{1'b0}};
    end else begin
      cnt_nxt_s = cnt_r + CNT_W'(1);
    end
  end

  // Next event count: clear wins over the count but never drops a same-cycle rise
  always_comb begin
    evt_nxt_s = evt_r;
    if (evt_clr) begin
      if (rise_r) begin
        evt_nxt_s = EVT_W'(1);
      end else begin
        evt_nxt_s = {EVT_W{1'b0}};
      end
    end else if (rise_r && !(&evt_r)) begin
      evt_nxt_s = evt_r + EVT_W'(1);
    end else begin
      evt_nxt_s = evt_r;
    end
  end

  // State registers; pulses are derived from the level transition being registered
  always_ff @(posedge dst_clk or posedge dst_rst) begin
    if (dst_rst) begin
      cnt_r  <= {CNT_W{1'b0}};
      out_r  <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
      evt_r  <= {EVT_W{1'b0}};
    end else begin
      cnt_r  <= cnt_nxt_s;
      out_r  <= out_nxt_s;
      rise_r <= ~out_r & out_nxt_s;
      fall_r <= out_r & ~out_nxt_s;
      evt_r  <= evt_nxt_s;
    end
  end

  assign out     = out_r;
  assign rise    = rise_r;
  assign fall    = fall_r;
  assign evt_cnt = evt_r;

endmodule

// File: rtl/sync_sig_filter.sv
// Multi-lane deglitch filter with edge pulses and event counters, placed after the
// two-flop synchronizer in the dst_clk domain. Lanes are fully independent.
module sync_sig_filter #(
  parameter int   WIDTH      = 1,
  parameter logic RST_VAL    = 1'b0,
  parameter int   FILTER_CYC = 4,
  parameter int   CNT_W      = 3,
  parameter int   EVT_W      = 16
) (
  input  logic                   dst_clk,
  input  logic                   dst_rst,
  input  logic [WIDTH-1:0]       in,
  output logic [WIDTH-1:0]       out,
  output logic [WIDTH-1:0]       rise,
  output logic [WIDTH-1:0]       fall,
  input  logic [WIDTH-1:0]       evt_clr,
  output logic [WIDTH*EVT_W-1:0] evt_cnt
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    sync_sig_filter_lane #(
      .RST_VAL   (RST_VAL),
      .FILTER_CYC(FILTER_CYC),
      .CNT_W     (CNT_W),
      .EVT_W     (EVT_W)
    ) u_lane (
      .dst_clk(dst_clk),
      .dst_rst(dst_rst),
      .in     (in[i]),
      .evt_clr(evt_clr[i]),
      .out    (out[i]),
      .rise   (rise[i]),
      .fall   (fall[i]),
      .evt_cnt(evt_cnt[i*EVT_W +: EVT_W])
    );
  end

endmodule

// File: tb/tb_sync_sig_filter.sv
// Self-checking bench: table-driven directed rows, hand-written corner sequences and
// randomized traffic compared against a sample-history reference model.
module tb_sync_sig_filter;

  logic       dst_clk = 1'b0;
  logic       dst_rst = 1'b1;
  logic [1:0] a_in = 2'b00, a_clr = 2'b00;
  logic [1:0] a_out, a_rise, a_fall;
  logic [5:0] a_evt;
  logic       c_out, c_rise, c_fall;
  logic [1:0] c_evt;
  logic [3:0] b_in = 4'h0, b_clr = 4'h0;
  logic [3:0] b_out, b_rise, b_fall;
  logic [63:0] b_evt;

  always #5 dst_clk = ~dst_clk;

  // A: filtered, 3-bit event counters
  sync_sig_filter #(.WIDTH(2), .RST_VAL(1'b0), .FILTER_CYC(4), .CNT_W(3), .EVT_W(3)) dut_a (
    .dst_clk(dst_clk), .dst_rst(dst_rst), .in(a_in), .out(a_out), .rise(a_rise),
    .fall(a_fall), .evt_clr(a_clr), .evt_cnt(a_evt));
  // C: same stimulus as lane 0 of A, 2-bit counter for saturation
  sync_sig_filter #(.WIDTH(1), .RST_VAL(1'b0), .FILTER_CYC(4), .CNT_W(3), .EVT_W(2)) dut_c (
    .dst_clk(dst_clk), .dst_rst(dst_rst), .in(a_in[0]), .out(c_out), .rise(c_rise),
    .fall(c_fall), .evt_clr(a_clr[0]), .evt_cnt(c_evt));
  // B: bypass, reset value 1
  sync_sig_filter #(.WIDTH(4), .RST_VAL(1'b1), .FILTER_CYC(0), .CNT_W(3), .EVT_W(16)) dut_b (
    .dst_clk(dst_clk), .dst_rst(dst_rst), .in(b_in), .out(b_out), .rise(b_rise),
    .fall(b_fall), .evt_clr(b_clr), .evt_cnt(b_evt));

  int n_chk = 0;
  int n_pass = 0;

  // reference model, filtered lanes: 0,1 = A lanes, 2 = C
  bit mh [3][4];
  bit m_out [3];
  bit m_rise [3];
  bit m_fall [3];
  int m_evt [3];
  int m_max [3] = '{7, 7, 3};
  // reference model, bypass lanes
  bit mb_out [4];
  bit mb_rise [4];
  bit mb_fall [4];
  int mb_evt [4];

  typedef struct {
    bit in; bit clr; bit out; bit rise; bit fall; int evt;
  } vec_t;
  vec_t tbl [20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  task automatic model_reset();
    for (int l = 0; l < 3; l++) begin
      for (int i = 0; i < 4; i++) mh[l][i] = 1'b0;
      m_out[l] = 1'b0; m_rise[l] = 1'b0; m_fall[l] = 1'b0; m_evt[l] = 0;
    end
    for (int l = 0; l < 4; l++) begin
      mb_out[l] = 1'b1; mb_rise[l] = 1'b0; mb_fall[l] = 1'b0; mb_evt[l] = 0;
    end
  endtask

  // output follows when the last 4 samples all differ from the current output
  task automatic model_edge_a(input int l, input bit x, input bit c);
    bit diff;
    if (c) m_evt[l] = m_rise[l] ? 1 : 0;
    else if (m_rise[l] && m_evt[l] < m_max[l]) m_evt[l]++;
    for (int i = 0; i < 3; i++) mh[l][i] = mh[l][i+1];
    mh[l][3] = x;
    diff = 1'b1;
    for (int i = 0; i < 4; i++) if (mh[l][i] == m_out[l]) diff = 1'b0;
    m_rise[l] = 1'b0; m_fall[l] = 1'b0;
    if (diff) begin
      m_rise[l] = x; m_fall[l] = !x; m_out[l] = x;
    end
  endtask

  task automatic model_edge_b(input int l, input bit x, input bit c);
    if (c) mb_evt[l] = mb_rise[l] ? 1 : 0;
    else if (mb_rise[l] && mb_evt[l] < 65535) mb_evt[l]++;
    mb_rise[l] = !mb_out[l] && x;
    mb_fall[l] = mb_out[l] && !x;
    mb_out[l] = x;
  endtask

  task automatic check_all();
    for (int l = 0; l < 2; l++) begin
      chk($sformatf("a%0d_out", l), 32'(a_out[l]), 32'(m_out[l]));
      chk($sformatf("a%0d_rise", l), 32'(a_rise[l]), 32'(m_rise[l]));
      chk($sformatf("a%0d_fall", l), 32'(a_fall[l]), 32'(m_fall[l]));
      chk($sformatf("a%0d_evt", l), 32'(a_evt[l*3 +: 3]), 32'(m_evt[l]));
    end
    chk("c_out", 32'(c_out), 32'(m_out[2]));
    chk("c_rise", 32'(c_rise), 32'(m_rise[2]));
    chk("c_fall", 32'(c_fall), 32'(m_fall[2]));
    chk("c_evt", 32'(c_evt), 32'(m_evt[2]));
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("b%0d_out", l), 32'(b_out[l]), 32'(mb_out[l]));
      chk($sformatf("b%0d_rise", l), 32'(b_rise[l]), 32'(mb_rise[l]));
      chk($sformatf("b%0d_fall", l), 32'(b_fall[l]), 32'(mb_fall[l]));
      chk($sformatf("b%0d_evt", l), 32'(b_evt[l*16 +: 16]), 32'(mb_evt[l]));
    end
  endtask

  task automatic tick();
    @(posedge dst_clk);
    for (int l = 0; l < 2; l++) model_edge_a(l, a_in[l], a_clr[l]);
    model_edge_a(2, a_in[0], a_clr[0]);
    for (int l = 0; l < 4; l++) model_edge_b(l, b_in[l], b_clr[l]);
    #1;
    check_all();
  endtask

  task automatic clean_edge();
    a_in[0] = 1'b1;
    repeat (4) tick();
    a_in[0] = 1'b0;
    repeat (4) tick();
  endtask

  int hold [2];

  initial begin
    //            in clr out rise fall evt
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    tbl[17] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1};
    tbl[18] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};

    // reset state
    model_reset();
    #12;
    chk("rst_a_out", 32'(a_out), 32'd0);
    chk("rst_a_pulses", 32'({a_rise, a_fall}), 32'd0);
    chk("rst_a_evt", 32'(a_evt), 32'd0);
    chk("rst_b_out", 32'(b_out), 32'hF);
    chk("rst_b_evt", b_evt[31:0], 32'd0);
    check_all();
    @(negedge dst_clk);
    dst_rst = 1'b0;

    // directed table on lane 0 of A
    for (int r = 0; r < 20; r++) begin
      a_in[0] = tbl[r].in;
      a_clr[0] = tbl[r].clr;
      tick();
      chk($sformatf("tbl%0d_out", r), 32'(a_out[0]), 32'(tbl[r].out));
      chk($sformatf("tbl%0d_rise", r), 32'(a_rise[0]), 32'(tbl[r].rise));
      chk($sformatf("tbl%0d_fall", r), 32'(a_fall[0]), 32'(tbl[r].fall));
      chk($sformatf("tbl%0d_evt", r), 32'(a_evt[2:0]), 32'(tbl[r].evt));
    end
    a_clr[0] = 1'b0;

    // async assert between edges clears at once
    #2;
    dst_rst = 1'b1;
    #1;
    chk("async_a_out", 32'(a_out), 32'd0);
    chk("async_b_out", 32'(b_out), 32'hF);
    model_reset();
    a_in = 2'b00;
    @(negedge dst_clk);
    dst_rst = 1'b0;

    // saturation: A counts to 7, C sticks at 3
    for (int k = 1; k <= 7; k++) begin
      clean_edge();
      chk($sformatf("sat_a_%0d", k), 32'(a_evt[2:0]), 32'(k));
      chk($sformatf("sat_c_%0d", k), 32'(c_evt), 32'(k < 3 ? k : 3));
    end
    // clear in the same cycle as a rise keeps the event, then clear alone zeroes
    a_in[0] = 1'b1;
    repeat (4) tick();
    chk("clr_rise_pulse", 32'(a_rise[0]), 32'd1);
    a_clr[0] = 1'b1;
    tick();
    chk("clr_rise_a", 32'(a_evt[2:0]), 32'd1);
    chk("clr_rise_c", 32'(c_evt), 32'd1);
    tick();
    chk("clr_only_a", 32'(a_evt[2:0]), 32'd0);
    a_clr[0] = 1'b0;
    a_in[0] = 1'b0;
    repeat (4) tick();

    // reset during a pending filter count aborts it
    a_in = 2'b11;
    tick();
    tick();
    #2;
    dst_rst = 1'b1;
    model_reset();
    #1;
    chk("pend_rst_out", 32'(a_out), 32'd0);
    @(negedge dst_clk);
    dst_rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("pend_out_%0d", k), 32'(a_out), 32'd0);
      chk($sformatf("pend_rise_%0d", k), 32'(a_rise), 32'd0);
    end
    tick();
    chk("pend_late_rise", 32'(a_rise), 32'd3);

    // randomized traffic against the model
    hold[0] = 0; hold[1] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int l = 0; l < 2; l++) begin
        if (hold[l] == 0) begin
          a_in[l] = 1'($urandom_range(0, 1));
          hold[l] = $urandom_range(1, 6);
        end
        hold[l]--;
        a_clr[l] = ($urandom_range(0, 15) == 0);
      end
      b_in = 4'($urandom);
      b_clr = 4'($urandom) & 4'($urandom) & 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
